alu_sequencer: RTL and testbench

- Multi-cycle control unit that sequences one ALU instruction at a time: read two operands from the register file, execute on the ALU, write the result back, and update the status flags.
- Sits between the instruction source (CU decode) and the shared 8-bit ALU and register file.
- Drives the ALU select and operand inputs directly.
- Accepts instructions over a valid/ready handshake.

---
 rtl/alu_sequencer_if.sv | 39 +++
 rtl/alu_sequencer.sv | 120 ++++++++++++
 tb/tb_alu_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
`default_nettype none
// ============================================================================
// alu_sequencer_if : instruction handshake, register-file and ALU bus
// Rev 1.0
// ============================================================================
interface alu_sequencer_if #(
  parameter int RAW = 3,
  parameter int DW  = 8
);
  logic           ins_valid;
  logic           ins_ready;
  logic [1:0]     ins_op;
  logic [RAW-1:0] ins_rd;
  logic [RAW-1:0] ins_ra;
  logic [RAW-1:0] ins_rb;
  logic [RAW-1:0] rf_raddr;
  logic [DW-1:0]  rf_rdata;
  logic           rf_we;
  logic [RAW-1:0] rf_waddr;
  logic [DW-1:0]  rf_wdata;
  logic [1:0]     alu_sel;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_out;
  logic           alu_co;
  logic           alu_z;

  modport master (
    input  ins_valid, ins_op, ins_rd, ins_ra, ins_rb, rf_rdata, alu_out, alu_co, alu_z,
    output ins_ready, rf_raddr, rf_we, rf_waddr, rf_wdata, alu_sel, alu_a, alu_b
  );

  modport slave (
    output ins_valid, ins_op, ins_rd, ins_ra, ins_rb, rf_rdata, alu_out, alu_co, alu_z,
    input  ins_ready, rf_raddr, rf_we, rf_waddr, rf_wdata, alu_sel, alu_a, alu_b
  );
endinterface

`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// alu_sequencer : read A, read B, execute, write back; one ALU op at a time.
// Optional overlap of WB with the next handshake via ALU_SEQ_OVERLAP_EN.
// Rev 1.0
// ============================================================================
module alu_sequencer #(
  parameter int RAW = 3,
  parameter int DW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_sequencer_if.master  bus,
  output logic             flag_c,
  output logic             flag_z,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_stateNext;
  logic           w_accept;
  logic [1:0]     r_op;
  logic [1:0]     r_aluSel;
  logic [RAW-1:0] r_rd;
  logic [RAW-1:0] r_rb;
  logic [RAW-1:0] r_raddr;
  logic [DW-1:0]  r_opA;
  logic [DW-1:0]  r_opB;
  logic [DW-1:0]  r_result;
  logic           r_cN;
  logic           r_zN;

`ifdef ALU_SEQ_OVERLAP_EN
  assign bus.ins_ready = (r_state == IDLE) || (r_state == WB);
`else
  assign bus.ins_ready = (r_state == IDLE);
`endif
  assign w_accept = bus.ins_valid && bus.ins_ready;

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_stateNext = RDA;
      RDA:     w_stateNext = RDB;
      RDB:     w_stateNext = EXEC;
      EXEC:    w_stateNext = WB;
      WB:      w_stateNext = w_accept ? RDA : IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_aluSel <= '0;
      r_rd     <= '0;
      r_rb     <= '0;
      r_raddr  <= '0;
      r_opA    <= '0;
      r_opB    <= '0;
      r_result <= '0;
      r_cN     <= 1'b0;
      r_zN     <= 1'b0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
    end else begin
      // Operand A's address goes out straight from the handshake so RDA presents it.
      if (w_accept) begin
        r_op    <= bus.ins_op;
        r_rd    <= bus.ins_rd;
        r_rb    <= bus.ins_rb;
        r_raddr <= bus.ins_ra;
      end
      if (r_state == RDA) r_raddr <= r_rb;
      if (r_state == RDB) begin
        r_opA    <= bus.rf_rdata;
        r_aluSel <= r_op;
      end
      if (r_state == EXEC) begin
        r_opB    <= bus.rf_rdata;
        r_result <= bus.alu_out;
        r_cN     <= bus.alu_co;
        r_zN     <= bus.alu_z;
      end
      if (r_state == WB) begin
        flag_c <= r_cN;
        flag_z <= r_zN;
      end
    end
  end

  // Operand B arrives from the register file's own output register during EXEC
  // and stays put for the whole cycle; r_opB keeps it visible afterwards.
  assign bus.alu_b    = (r_state == EXEC) ? bus.rf_rdata : r_opB;
  assign bus.alu_a    = r_opA;
  assign bus.alu_sel  = r_aluSel;
  assign bus.rf_raddr = r_raddr;
  assign bus.rf_we    = (r_state == WB);
  assign bus.rf_waddr = r_rd;
  assign bus.rf_wdata = r_result;
  assign busy         = (r_state != IDLE);
  assign done         = (r_state == WB);

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_sequencer : register file + ALU environment with a timeline model.
// Rev 1.0
// ============================================================================
module tb_alu_sequencer;

`ifdef ALU_SEQ_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flag_c, flag_z, busy, done;

  alu_sequencer_if #(.RAW(3), .DW(8)) bus ();

  alu_sequencer #(.RAW(3), .DW(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .busy   (busy),
    .done   (done)
  );

  initial forever #5 clk = ~clk;

  int nChecks = 0;
  int nErr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Environment ALU: {carry, zero, result}
  function automatic logic [9:0] aluF(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    case (op)
      2'd0:    s = {1'b0, a} + {1'b0, b};
      2'd1:    s = {1'b0, a} - {1'b0, b};
      2'd2:    s = {1'b0, a & b};
      default: s = {1'b0, a | b};
    endcase
    return {s[8], (s[7:0] == 8'd0), s[7:0]};
  endfunction

  logic [9:0] aluRes;
  assign aluRes      = aluF(bus.alu_sel, bus.alu_a, bus.alu_b);
  assign bus.alu_out = aluRes[7:0];
  assign bus.alu_z   = aluRes[8];
  assign bus.alu_co  = aluRes[9];

  // Register file with synchronous read plus a backdoor port for preloading.
  logic [7:0] mem [0:7];
  logic       bdWe = 1'b0;
  logic [2:0] bdAddr = '0;
  logic [7:0] bdData = '0;

  initial begin
    logic [7:0] rdTmp;
    for (int i = 0; i < 8; i++) mem[i] = 8'd0;
    bus.rf_rdata = 8'd0;
    forever begin
      @(posedge clk);
      rdTmp = mem[bus.rf_raddr];
      if (bus.rf_we) mem[bus.rf_waddr] = bus.rf_wdata;
      if (bdWe) mem[bdAddr] = bdData;
      bus.rf_rdata <= rdTmp;
    end
  end

  // Timeline model: an accepted instruction is at phase edgeCnt-curA;
  // phases 0..3 are read A, read B, execute, write back.
  int         edgeCnt = 0;
  int         lastAccEdge = -100;
  int         nextFree = 0;
  bit         curValid = 1'b0;
  int         curA = 0;
  logic [1:0] curOp;
  logic [2:0] curRd, curRa, curRb;
  logic [7:0] curAv, curBv, curRes;
  logic       curC, curZ;
  logic [7:0] mdl [0:7];
  logic       expFC = 1'b0, expFZ = 1'b0;
  logic [1:0] holdSel = '0;
  logic [7:0] holdA = '0, holdB = '0;

  task automatic modelStep();
    logic [9:0] r;
    edgeCnt++;
    if (!rst_n) begin
      curValid = 1'b0;
      expFC = 1'b0; expFZ = 1'b0;
      holdSel = '0; holdA = '0; holdB = '0;
      nextFree = edgeCnt;
      return;
    end
    if (bdWe) mdl[bdAddr] = bdData;
    if (curValid && edgeCnt == curA + 4) begin
      mdl[curRd] = curRes;
      expFC = curC;
      expFZ = curZ;
    end
    if (curValid && edgeCnt == curA + 2) begin
      holdSel = curOp; holdA = curAv; holdB = curBv;
    end
    if (bus.ins_valid && edgeCnt >= nextFree) begin
      curValid = 1'b1;
      curA = edgeCnt;
      curOp = bus.ins_op; curRd = bus.ins_rd; curRa = bus.ins_ra; curRb = bus.ins_rb;
      curAv = mdl[curRa]; curBv = mdl[curRb];
      r = aluF(curOp, curAv, curBv);
      curRes = r[7:0]; curZ = r[8]; curC = r[9];
      nextFree = edgeCnt + (OVL ? 4 : 5);
      lastAccEdge = edgeCnt;
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mdl[i] = 8'd0;
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  int         wbCyc [$];
  logic [2:0] wbAddr [$];
  logic [7:0] wbData [$];

  task automatic compareStep();
    int p;
    bit live;
    if (!rst_n) begin
      chk("rst_ready", 32'(bus.ins_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_we_done", 32'({bus.rf_we, done}), 0);
      chk("rst_flags", 32'({flag_c, flag_z}), 0);
      chk("rst_alu", 32'({bus.alu_sel, bus.alu_a, bus.alu_b}), 0);
      chk("rst_addr", 32'({bus.rf_raddr, bus.rf_waddr, bus.rf_wdata}), 0);
      return;
    end
    p = curValid ? edgeCnt - curA : 100;
    live = curValid && (p <= 3);
    if (bus.rf_we) begin
      wbCyc.push_back(edgeCnt);
      wbAddr.push_back(bus.rf_waddr);
      wbData.push_back(bus.rf_wdata);
    end
    chk("busy", 32'(busy), 32'(live));
    chk("ins_ready", 32'(bus.ins_ready), live ? 32'(OVL && p == 3) : 1);
    chk("rf_we", 32'(bus.rf_we), 32'(live && p == 3));
    chk("done", 32'(done), 32'(live && p == 3));
    chk("flag_c", 32'(flag_c), 32'(expFC));
    chk("flag_z", 32'(flag_z), 32'(expFZ));
    chk("alu_sel", 32'(bus.alu_sel), 32'(holdSel));
    chk("alu_a", 32'(bus.alu_a), 32'(holdA));
    chk("alu_b", 32'(bus.alu_b), 32'(holdB));
    if (live && p == 0) chk("raddr_a", 32'(bus.rf_raddr), 32'(curRa));
    if (live && p == 1) chk("raddr_b", 32'(bus.rf_raddr), 32'(curRb));
    if (live && p == 3) begin
      chk("waddr", 32'(bus.rf_waddr), 32'(curRd));
      chk("wdata", 32'(bus.rf_wdata), 32'(curRes));
    end
  endtask

  initial forever begin
    @(negedge clk);
    compareStep();
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic backdoor(input logic [2:0] a, input logic [7:0] d);
    bdWe = 1'b1; bdAddr = a; bdData = d;
    step(1);
    bdWe = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb);
    bus.ins_valid = 1'b1;
    bus.ins_op = op; bus.ins_rd = rd; bus.ins_ra = ra; bus.ins_rb = rb;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (lastAccEdge == edgeCnt) begin
        bus.ins_valid = 1'b0;
        bus.ins_op = 2'($urandom_range(3));
        bus.ins_rd = 3'($urandom_range(7));
        bus.ins_ra = 3'($urandom_range(7));
        bus.ins_rb = 3'($urandom_range(7));
        return;
      end
    end
    chk("issue_timeout", 0, 1);
    bus.ins_valid = 1'b0;
  endtask

  task automatic lastWb(input string nm, input int n0, input logic [2:0] a, input logic [7:0] d);
    if (wbData.size() <= n0) chk({nm, "_missing"}, 32'(wbData.size()), 32'(n0 + 1));
    else begin
      chk({nm, "_addr"}, 32'(wbAddr[n0]), 32'(a));
      chk({nm, "_data"}, 32'(wbData[n0]), 32'(d));
    end
  endtask

  initial begin
    int n0;
    bus.ins_valid = 1'b0;
    bus.ins_op = '0; bus.ins_rd = '0; bus.ins_ra = '0; bus.ins_rb = '0;
    step(3);
    rst_n = 1'b1;
    step(5);
    chk("idle_ready", 32'(bus.ins_ready), 1);
    chk("idle_busy_we_done", 32'({busy, bus.rf_we, done}), 0);
    chk("idle_flags", 32'({flag_c, flag_z}), 0);

    // 5 - 5: zero result, no borrow
    backdoor(3'd1, 8'h05);
    backdoor(3'd2, 8'h05);
    n0 = wbData.size();
    issue(2'b01, 3'd3, 3'd1, 3'd2);
    step(6);
    lastWb("sub", n0, 3'd3, 8'h00);
    chk("sub_flags", 32'({flag_c, flag_z}), 32'(2'b01));

    // Back-to-back with valid held high across the two handshakes
    backdoor(3'd4, 8'h08);
    backdoor(3'd5, 8'h02);
    backdoor(3'd6, 8'h0C);
    backdoor(3'd7, 8'h2D);
    n0 = wbData.size();
    issue(2'b00, 3'd0, 3'd4, 3'd5);
    issue(2'b10, 3'd1, 3'd6, 3'd7);
    step(7);
    lastWb("b2b_first", n0, 3'd0, 8'h0A);
    lastWb("b2b_second", n0 + 1, 3'd1, 8'h0C);
    if (wbCyc.size() >= n0 + 2)
      chk("b2b_spacing", 32'(wbCyc[n0 + 1] - wbCyc[n0]), OVL ? 4 : 5);

    // rd == ra == rb, zero operand
    backdoor(3'd6, 8'h00);
    n0 = wbData.size();
    issue(2'b00, 3'd6, 3'd6, 3'd6);
    step(6);
    lastWb("same_reg", n0, 3'd6, 8'h00);
    chk("same_reg_flag_z", 32'(flag_z), 1);

    // Reset asserted during EXEC aborts the write-back
    n0 = wbData.size();
    issue(2'b00, 3'd2, 3'd1, 3'd4);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_busy_done", 32'({bus.rf_we, busy, done}), 0);
    chk("abort_flags", 32'({flag_c, flag_z}), 0);
    chk("abort_alu", 32'({bus.alu_sel, bus.alu_a, bus.alu_b}), 0);
    chk("abort_ready", 32'(bus.ins_ready), 1);
    step(2);
    rst_n = 1'b1;
    step(2);
    chk("abort_no_wb", 32'(wbData.size()), 32'(n0));
    chk("abort_r2_kept", 32'(mem[2]), 32'h05);
    issue(2'b00, 3'd2, 3'd1, 3'd4);
    step(6);
    lastWb("after_abort", n0, 3'd2, 8'h14);

    // Randomized stream with changing fields while busy
    for (int i = 0; i < 300; i++) begin
      bus.ins_valid = ($urandom_range(9) < 6);
      bus.ins_op = 2'($urandom_range(3));
      bus.ins_rd = 3'($urandom_range(7));
      bus.ins_ra = 3'($urandom_range(7));
      bus.ins_rb = 3'($urandom_range(7));
      step(1);
    end
    bus.ins_valid = 1'b0;
    step(8);

    for (int i = 0; i < 8; i++) chk($sformatf("rf_final_r%0d", i), 32'(mem[i]), 32'(mdl[i]));

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule

`default_nettype wire
